// File: rtl/imem_boot_loader_ctrl_pkg.sv
// Shared constants and state type for the instruction-memory boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_boot_loader_ctrl_pkg;

  localparam int unsigned DEPTH    = 128;
  localparam int unsigned CNT_W    = 8;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Memory port direction encoding, shared with the instruction memory.
  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } ldr_state_t;

endpackage

// File: rtl/imem_boot_loader_ctrl_byte_packer.sv
// Packs four serial bytes into one big-endian 32-bit word (first byte -> [31:24]).
// Latency: word valid the cycle after the 4th shift; word_full flags that 4th shift.
// Backpressure: none; the owner gates shift_en and clears between words.
module imem_boot_loader_ctrl_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);

  logic [1:0] byte_cnt;

  // Shift register and byte count; clear wins over a same-cycle shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_out <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      word_out <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      word_out <= {word_out[23:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // High when the byte being shifted this cycle completes the word.
  assign word_full = shift_en && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_boot_loader_ctrl.sv
// Shares the instruction memory port between CPU fetch (RUN) and a byte-serial loader.
// Latency: fetch is combinational pass-through; each loaded word is written 1 cycle after its 4th byte.
// Backpressure: byte_ready only in LOAD; CPU held by cpu_stall for the whole load.
module imem_boot_loader_ctrl #(
  parameter int unsigned DEPTH    = imem_boot_loader_ctrl_pkg::DEPTH,
  parameter int unsigned CNT_W    = imem_boot_loader_ctrl_pkg::CNT_W,
  parameter logic [31:0] NOP_WORD = imem_boot_loader_ctrl_pkg::NOP_WORD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic [CNT_W-1:0] load_len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  input  logic [31:0]      cpu_fetch_addr,
  output logic [31:0]      cpu_instr,
  output logic             cpu_stall,
  output logic             cpu_pc_reset,
  output logic             addr_err,
  output logic             mem_rw,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             load_busy,
  output logic             load_done,
  output logic [CNT_W-1:0] words_loaded
);

  import imem_boot_loader_ctrl_pkg::*;

  // One extra bit so a length of exactly 2^CNT_W words stays representable.
  localparam int unsigned      LEN_W   = CNT_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  ldr_state_t       state;
  ldr_state_t       state_nxt;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] wr_idx;
  logic [LEN_W-1:0] load_len_ext;
  logic [LEN_W-1:0] len_clamped;
  logic [LEN_W-1:0] wr_idx_nxt;
  logic [31:0]      wr_addr;
  logic             load_accept;
  logic             fetch_bad;
  logic             pk_clear;
  logic             pk_shift;
  logic             pk_full;
  logic [31:0]      pk_word;

  assign load_len_ext = {1'b0, load_len};
  assign len_clamped  = ((load_len_ext == '0) || (load_len_ext > DEPTH_L)) ? DEPTH_L : load_len_ext;
  assign wr_idx_nxt   = {1'b0, wr_idx} + LEN_W'(1);
  assign wr_addr      = {{(32 - CNT_W - 2){1'b0}}, wr_idx, 2'b00};
  assign fetch_bad    = (cpu_fetch_addr[1:0] != 2'b00) || (cpu_fetch_addr[31:2] >= 30'(DEPTH));
  assign load_accept  = (state == ST_RUN) && load_start;

  // Packer shifts only on a real transfer and is emptied at load start and after each write.
  assign pk_shift  = (state == ST_LOAD) && byte_valid;
  assign pk_clear  = load_accept || (state == ST_WRITE);
  assign mem_wdata = pk_word;

  imem_boot_loader_ctrl_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .shift_en  (pk_shift),
    .byte_in   (byte_data),
    .word_out  (pk_word),
    .word_full (pk_full)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Load length, write index and word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len          <= '0;
      wr_idx       <= '0;
      words_loaded <= '0;
    end else if (load_accept) begin
      len          <= len_clamped;
      wr_idx       <= '0;
      words_loaded <= '0;
    end else if (state == ST_WRITE) begin
      wr_idx       <= wr_idx + CNT_W'(1);
      words_loaded <= words_loaded + CNT_W'(1);
    end
  end

  // Next-state and output decode; the memory port only writes in WRITE.
  always_comb begin
    state_nxt    = state;
    mem_rw       = MEM_READ;
    mem_addr     = wr_addr;
    cpu_instr    = NOP_WORD;
    cpu_stall    = 1'b1;
    byte_ready   = 1'b0;
    addr_err     = 1'b0;
    cpu_pc_reset = 1'b0;
    load_done    = 1'b0;
    load_busy    = 1'b1;
    case (state)
      ST_RUN: begin
        cpu_stall = 1'b0;
        load_busy = 1'b0;
        mem_addr  = cpu_fetch_addr;
        addr_err  = fetch_bad;
        cpu_instr = fetch_bad ? NOP_WORD : mem_rdata;
        if (load_start) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        byte_ready = 1'b1;
        if (pk_full) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_rw    = MEM_WRITE;
        state_nxt = (wr_idx_nxt == len) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        load_done    = 1'b1;
        cpu_pc_reset = 1'b1;
        state_nxt    = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

endmodule

// File: doc/imem_boot_loader_ctrl.md
Name: imem_boot_loader_ctrl

Overview:
Controller that owns the 128-word instruction memory port and shares it between CPU instruction fetch and a byte-serial program loader (UART side).
- In RUN it passes CPU fetches straight through to memory.
- On a load request it stalls the CPU, packs incoming bytes into big-endian words and writes them sequentially from word 0.
- When loading finishes it pulses a PC restart.
- Sits between the PC/fetch stage, the loader front-end and the instruction memory's read/write port (mem_rw: 1 = read, 0 = write).

Parameters:
- DEPTH, 128, number of 32-bit words in instruction memory
- CNT_W, 8, width of word index/counters; must satisfy 2^CNT_W >= DEPTH
- NOP_WORD, 32'h00000000, instruction returned to CPU while stalled or on a bad fetch address

Ports:
- CLK  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- load_start  input  1  one-cycle request to begin a program load; honoured only in RUN
- load_len  input  CNT_W  words to load, sampled on accepted load_start; 0 or >DEPTH means DEPTH
- byte_valid  input  1  loader byte available
- byte_data  input  8  loader byte
- byte_ready  output  1  controller accepts byte this cycle (transfer = byte_valid & byte_ready)
- cpu_fetch_addr  input  32  byte address from PC
- cpu_instr  output  32  instruction to decode stage
- cpu_stall  output  1  CPU must hold PC and not commit
- cpu_pc_reset  output  1  one-cycle pulse: CPU reloads PC to 0
- addr_err  output  1  current fetch is misaligned or beyond DEPTH (RUN only)
- mem_rw  output  1  memory control: 1 = read, 0 = write
- mem_addr  output  32  memory byte address
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory read data, combinational from mem_addr
- load_busy  output  1  high in LOAD/WRITE/DONE
- load_done  output  1  one-cycle pulse when load completes
- words_loaded  output  CNT_W  words written in current/last load

Behaviour:
- Reset (async, Reset=0) drives state RUN and clears all counters. Outputs at reset:
  - mem_rw=1, cpu_stall=0, byte_ready=0, load_done=0, cpu_pc_reset=0, words_loaded=0
  - packer empty, mem_wdata=0
- States: RUN, LOAD, WRITE, DONE. All state and counters are registered; outputs are decoded from state.
- RUN:
  - mem_rw=1, mem_addr=cpu_fetch_addr, cpu_stall=0, byte_ready=0.
  - Zero-latency fetch: cpu_instr=mem_rdata in the same cycle.
  - addr_err=1 when cpu_fetch_addr[1:0]!=0 or cpu_fetch_addr[31:2]>=DEPTH; in that case cpu_instr=NOP_WORD.
  - load_start=1 -> LOAD next cycle. Same edge: latch len (0 or >DEPTH -> DEPTH), clear wr_idx, words_loaded and packer.
- LOAD:
  - cpu_stall=1, cpu_instr=NOP_WORD, mem_rw=1, byte_ready=1, addr_err=0.
  - Each byte transfer shifts into the packer. First byte goes to [31:24], fourth to [7:0].
  - On the 4th byte transfer -> WRITE next cycle.
  - byte_valid=0 simply holds; there is no timeout.
- WRITE (exactly 1 cycle):
  - mem_rw=0, mem_addr={wr_idx,2'b00} zero-extended to 32 bits, mem_wdata=packed word, byte_ready=0.
  - At the edge, wr_idx and words_loaded increment and the packer clears.
  - Next state: DONE if wr_idx+1==len, else LOAD.
- DONE (exactly 1 cycle):
  - load_done=1, cpu_pc_reset=1, cpu_stall=1, mem_rw=1, byte_ready=0.
  - Next state: RUN. The first fetch after load is address 0, in the cycle after DONE.
- load_start outside RUN is ignored.
- byte_valid outside LOAD is ignored; no byte is consumed.
- Writes never exceed DEPTH-1, because len is clamped.
- Reset mid-load: returns to RUN immediately. Memory keeps words already written; a partial packer word is discarded; no load_done or cpu_pc_reset pulse is issued.
- mem_rw=0 only in WRITE, so a CPU read and a loader write never coincide.

Decomposition:
- Shared package holds:
  - state enum (RUN, LOAD, WRITE, DONE)
  - NOP_WORD
  - DEPTH and the MEM_READ=1 / MEM_WRITE=0 constants, reused by the instruction memory
- Sub-module byte_packer:
  - 8-to-32 shift register with a 2-bit byte count
  - ports: clk, async active-low reset, clear, shift_en, byte_in, word_out, word_full

Test Plan:
1. Reset, then fetch 0x00000004 with mem_rdata=0x20090001 -> same cycle cpu_instr=0x20090001, cpu_stall=0, mem_rw=1, addr_err=0.
2. Fetch 0x00000006 and 0x00000200 -> addr_err=1, cpu_instr=0x00000000, for each.
3. load_start with load_len=2, bytes 20 08 00 00 01 09 50 2A with gaps in byte_valid:
   - WRITE cycles show addr 0x0 / data 0x20080000, then addr 0x4 / data 0x0109502A, with mem_rw=0 only in those cycles.
   - Then load_done=1 and cpu_pc_reset=1 for one cycle, words_loaded=2, cpu_stall falls the next cycle.
4. load_len=0 -> exactly 128 WRITE cycles, last at mem_addr=0x1FC, then DONE.
5. load_start asserted during LOAD, and byte_valid held high during WRITE -> no restart, no byte lost or duplicated (packed words match the byte stream).
6. Reset=0 after 1 word plus 2 bytes of a load -> immediate RUN, cpu_stall=0, no load_done pulse, words_loaded=0; next load starts at address 0.
